// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that gives NUM_REQ write requesters access to the
//   write port of a single FIFO memory. All logic is clocked on posedge wclk.
//
//   Optional feature macro: WR_ARB_BURST_EN
//     defined   - a granted requester keeps the port for up to BURST_LEN
//                 transfers while it stays valid.
//     undefined - every transfer ends the grant (round-robin per word);
//                 BURST_LEN is ignored.
//
//   Ports
//     wclk        in   write clock
//     wrst        in   synchronous active-high reset
//     req_valid   in   [NUM_REQ]             per-requester write request
//     req_data    in   [NUM_REQ*DATA_WIDTH]  payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//     req_ready   out  [NUM_REQ]             accept strobe, at most one bit high
//     full        in   FIFO full flag
//     w_en        out  FIFO memory write enable
//     data_in     out  [DATA_WIDTH]          FIFO memory write data
//     grant_valid out  a requester holds the grant
//     grant_id    out  [3]                   index of the granted requester
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BURST_LEN  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          w_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic                          grant_valid,
  output logic [2:0]                    grant_id
);

  localparam int unsigned IW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [IW-1:0]   gid;
  logic [IW-1:0]   last_id;
`ifdef WR_ARB_BURST_EN
  logic [3:0]      burst_cnt;
`endif

  logic            cur_valid;
  logic            xfer;
  logic            grant_end;
  logic [NUM_REQ-1:0] others;
  logic [IW:0]     idle_pick;
  logic [IW:0]     next_pick;

  // Returns {found, index}: first set bit of v searching upward from from+1
  // with wrap-around.
  function automatic logic [IW:0] pick(input logic [NUM_REQ-1:0] v,
                                       input logic [IW-1:0]      from);
    logic          found;
    logic [IW-1:0] idx;
    int unsigned   i;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      i = (32'(from) + k) % NUM_REQ;
      if (!found && v[i]) begin
        found = 1'b1;
        idx   = IW'(i);
      end
    end
    return {found, idx};
  endfunction

  always_comb begin
    cur_valid   = req_valid[gid];
    // Rearbitration at the end of a grant only considers other requesters.
    others      = req_valid;
    others[gid] = 1'b0;
    idle_pick   = pick(req_valid, last_id);
    next_pick   = pick(others, gid);
    xfer        = (state == GRANT) && cur_valid && !full && !wrst;
`ifdef WR_ARB_BURST_EN
    grant_end   = xfer && (burst_cnt == 4'(BURST_LEN - 1));
`else
    grant_end   = xfer;
`endif
    w_en        = xfer;
    req_ready   = '0;
    if ((state == GRANT) && !full && !wrst)
      req_ready[gid] = 1'b1;
    data_in     = req_data[gid*DATA_WIDTH +: DATA_WIDTH];
  end

  assign grant_valid = (state == GRANT);
  assign grant_id    = 3'(gid);

  always_ff @(posedge wclk) begin
    if (wrst) begin
      state     <= IDLE;
      gid       <= '0;
      last_id   <= IW'(NUM_REQ - 1);
`ifdef WR_ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (idle_pick[IW]) begin
            state     <= GRANT;
            gid       <= idle_pick[IW-1:0];
`ifdef WR_ARB_BURST_EN
            burst_cnt <= '0;
`endif
          end
        end
        GRANT: begin
          // While full, everything is frozen.
          if (!full) begin
            if (!cur_valid) begin
              state   <= IDLE;
              last_id <= gid;
            end else if (grant_end) begin
              last_id <= gid;
`ifdef WR_ARB_BURST_EN
              burst_cnt <= '0;
`endif
              if (next_pick[IW])
                gid   <= next_pick[IW-1:0];
              else
                state <= IDLE;
            end
`ifdef WR_ARB_BURST_EN
            else begin
              burst_cnt <= burst_cnt + 4'd1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
//   BURST_LEN=4). Follows WR_ARB_BURST_EN if defined for the build.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;
`ifdef WR_ARB_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic            wclk = 1'b0;
  logic            wrst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            full = 1'b0;
  logic            w_en;
  logic [DW-1:0]   data_in;
  logic            grant_valid;
  logic [2:0]      grant_id;

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .NUM_REQ   (N),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .full       (full),
    .w_en       (w_en),
    .data_in    (data_in),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 = nobody), last winner, transfers in grant.
  int m_owner = -1;
  int m_last  = N - 1;
  int m_cnt   = 0;

  function automatic int next_id(input logic [N-1:0] v, input int from);
    for (int k = 1; k <= N; k++) begin
      if (v[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                       input logic f, input logic r);
    @(negedge wclk);
    req_valid = v;
    req_data  = d;
    full      = f;
    wrst      = r;
    #1;
  endtask

  // Compare outputs against the model, then let the clock edge happen and
  // advance the model with the same inputs.
  task automatic settle();
    logic         exp_w;
    logic [N-1:0] exp_r;
    logic [N-1:0] o;
    exp_w = !wrst && (m_owner >= 0) && req_valid[m_owner] && !full;
    exp_r = (!wrst && (m_owner >= 0) && !full) ? (N'(1) << m_owner) : '0;
    chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
    if (m_owner >= 0) chk("grant_id", 32'(grant_id), 32'(m_owner));
    chk("w_en", 32'(w_en), 32'(exp_w));
    chk("req_ready", 32'(req_ready), 32'(exp_r));
    if (exp_w) chk("data_in", 32'(data_in), 32'(req_data[m_owner*DW +: DW]));
    @(posedge wclk);
    if (wrst) begin
      m_owner = -1;
      m_last  = N - 1;
      m_cnt   = 0;
    end else if (m_owner < 0) begin
      m_owner = next_id(req_valid, m_last);
      m_cnt   = 0;
    end else if (!full) begin
      if (!req_valid[m_owner]) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_cnt++;
        if (!BURST || m_cnt >= BL) begin
          o          = req_valid;
          o[m_owner] = 1'b0;
          m_last     = m_owner;
          m_owner    = next_id(o, m_last);
          m_cnt      = 0;
        end
      end
    end
  endtask

  task automatic do_reset();
    drive('0, '0, 1'b0, 1'b1);
    settle();
  endtask

  int exp_seq [8];

  initial begin
    if (BURST) exp_seq = '{0, 0, 0, 0, 1, 1, 1, 1};
    else       exp_seq = '{0, 1, 2, 3, 0, 1, 2, 3};

    // Reset with all requesters valid: nothing may be written.
    drive('1, '0, 1'b0, 1'b1);
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    settle();
    drive('1, '0, 1'b0, 1'b1);
    chk("rst_gv", 32'(grant_valid), 32'd0);
    chk("rst_gid", 32'(grant_id), 32'd0);
    settle();

    // Single requester 0 with 8'hA5.
    drive(4'b0001, 32'h0000_00A5, 1'b0, 1'b0);
    chk("first_idle_gv", 32'(grant_valid), 32'd0);
    chk("first_idle_wen", 32'(w_en), 32'd0);
    settle();
    drive(4'b0001, 32'h0000_00A5, 1'b0, 1'b0);
    chk("first_gv", 32'(grant_valid), 32'd1);
    chk("first_gid", 32'(grant_id), 32'd0);
    chk("first_wen", 32'(w_en), 32'd1);
    chk("first_data", 32'(data_in), 32'hA5);
    settle();
    drive('0, '0, 1'b0, 1'b0);
    settle();
    drive('0, '0, 1'b0, 1'b0);
    settle();

    // All four valid: rotation (or bursts) with no bubbles.
    do_reset();
    drive('1, $urandom, 1'b0, 1'b0);
    settle();
    for (int i = 0; i < 8; i++) begin
      drive('1, $urandom, 1'b0, 1'b0);
      chk("seq_gid", 32'(grant_id), 32'(exp_seq[i]));
      chk("seq_wen", 32'(w_en), 32'd1);
      settle();
    end

    // full held for 3 cycles during a grant to requester 2.
    do_reset();
    drive(4'b0100, 32'h0033_0000, 1'b0, 1'b0);
    settle();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0100, 32'h0033_0000, 1'b1, 1'b0);
      chk("full_gid", 32'(grant_id), 32'd2);
      chk("full_wen", 32'(w_en), 32'd0);
      chk("full_ready", 32'(req_ready), 32'd0);
      settle();
    end
    drive(4'b0100, 32'h0033_0000, 1'b0, 1'b0);
    chk("unfull_wen", 32'(w_en), 32'd1);
    chk("unfull_data", 32'(data_in), 32'h33);
    settle();

    // Reset asserted mid-grant.
    do_reset();
    drive('1, $urandom, 1'b0, 1'b0);
    settle();
    drive('1, $urandom, 1'b0, 1'b0);
    settle();
    drive('1, $urandom, 1'b0, 1'b1);
    chk("midrst_wen", 32'(w_en), 32'd0);
    chk("midrst_ready", 32'(req_ready), 32'd0);
    settle();
    drive('1, $urandom, 1'b0, 1'b0);
    chk("postrst_gv", 32'(grant_valid), 32'd0);
    settle();
    drive('1, $urandom, 1'b0, 1'b0);
    chk("postrst_gid", 32'(grant_id), 32'd0);
    chk("postrst_gv1", 32'(grant_valid), 32'd1);
    settle();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      drive(N'($urandom_range(0, 15)), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 59) == 0));
      settle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of write requesters (2..8); DATA_WIDTH, default 8, payload width; BURST_LEN, default 4, maximum writes per grant (1..15).
REQ-002 wclk  input  1  write clock; single clock, all logic on posedge wclk.
REQ-003 wrst  input  1  reset, synchronous, active-high.
REQ-004 req_valid  input  NUM_REQ  per-requester write request.
REQ-005 req_data  input  NUM_REQ*DATA_WIDTH  payloads; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-006 req_ready  output  NUM_REQ  per-requester accept strobe; at most one bit high.
REQ-007 full  input  1  FIFO full flag, write domain.
REQ-008 w_en  output  1  FIFO memory write enable.
REQ-009 data_in  output  DATA_WIDTH  FIFO memory write data.
REQ-010 grant_valid  output  1  a requester currently holds the grant.
REQ-011 grant_id  output  3  index of the granted requester.

Function
REQ-012 FSM SHALL have two states: IDLE (no grant) and GRANT (grant_id owns the write port).
REQ-013 IDLE -> GRANT SHALL occur on the first clock where any req_valid is high; grant_id is set to the first valid index searching upward, with wrap-around, from last_id+1.
REQ-014 Arbitration latency SHALL be 1 cycle: a request seen in IDLE is first writable on the next cycle.
REQ-015 In GRANT: req_ready[grant_id] = !full; w_en = req_valid[grant_id] & !full; data_in = req_data[grant_id]; all three are combinational, with no added latency.
REQ-016 A transfer SHALL be a cycle with w_en=1; exactly one FIFO write occurs per transfer.
REQ-017 While full=1, the grant SHALL be held: w_en=0, all req_ready=0, and the grant is not rotated.
REQ-018 A transfer that ends the grant (REQ-020) SHALL set last_id=grant_id and rearbitrate in the same cycle: if another request is pending, the next state is GRANT with the new id (back-to-back, no bubble); otherwise the next state is IDLE.
REQ-019 If req_valid[grant_id] drops with no transfer, the FSM SHALL return to IDLE next cycle with last_id=grant_id.
REQ-020 A grant SHALL end after a transfer per the Configuration rules.
REQ-021 Non-granted requesters SHALL see req_ready=0 at all times.
REQ-022 grant_id SHALL be zero-extended when NUM_REQ<8; unused index values are never granted.

Reset
REQ-023 While wrst=1: state=IDLE, grant_valid=0, grant_id=0, w_en=0, req_ready=0, burst count=0, last_id=NUM_REQ-1 (requester 0 wins first).
REQ-024 w_en and req_ready SHALL be forced to 0 in any cycle where wrst=1, including a reset asserted mid-grant; no write leaks.

Configuration
REQ-025 Macro WR_ARB_BURST_EN: when defined, a 4-bit burst counter SHALL keep the grant while req_valid[grant_id]=1 until BURST_LEN transfers are done; the grant ends on the BURST_LEN-th transfer, and the counter clears on each new grant.
REQ-026 When WR_ARB_BURST_EN is undefined: the counter is not built, BURST_LEN is ignored, and every transfer ends the grant (strict round-robin per word).

Verification
REQ-027 Reset, then req_valid=4'b0001, data 8'hA5, full=0 -> grant_valid=1 and grant_id=0 next cycle; w_en=1 with data_in=8'hA5 in that cycle.
REQ-028 All four requesters valid continuously, burst off -> grant_id sequence 0,1,2,3,0, with w_en=1 every cycle after the first.
REQ-029 Burst on, BURST_LEN=4, all four requesters valid -> 4 writes from id 0, then 4 from id 1, with no idle cycle between bursts.
REQ-030 full=1 for 3 cycles during a grant to id 2 -> w_en=0 and req_ready=0 for those 3 cycles, grant_id stays 2, and the write completes on the cycle full falls.
REQ-031 wrst=1 asserted mid-burst with req_valid=4'b1111 -> w_en=0 in the reset cycle; after release, the first grant goes to id 0.
